mc_controller_hs: RTL
=====================

// Module: mc_controller_hs
// PURPOSE
//  Multicycle MIPS control unit with a memory ready/request handshake. Decodes
//  op/funct, steps the datapath FSM, drives all datapath mux selects and write
//  enables, and produces the 3-bit ALU control directly. Adds ADDI, J, BNE and
//  an illegal-instruction trap state. Sits between the instruction register and
//  the multicycle datapath/unified memory.
// PARAMETERS
//  MEM_WAIT_EN  1  1: FETCH/MEMRD/MEMWR hold until mem_ready_i; 0: mem_ready_i treated as 1
//  EXT_OPS_EN   1  1: ADDI/J/BNE decoded; 0: those opcodes trap as illegal
// PORTS
//  clk_i            in   1  clock, rising edge
//  reset_i          in   1  asynchronous, active-low reset
//  op_i6            in   6  instruction opcode [31:26]
//  funct_i6         in   6  R-type funct [5:0]
//  zero_i           in   1  ALU zero flag
//  mem_ready_i      in   1  memory completes current access this cycle
//  mem_req_o        out  1  memory access requested (FETCH, MEMRD, MEMWR)
//  enable_wmem_o    out  1  MemWrite
//  pc_we_o          out  1  PC write enable (PCWrite | branch taken)
//  pc_branch_o2     out  2  PCSrc: 00 ALUResult, 01 ALUOut, 10 jump target
//  instr_or_data_o  out  1  IorD: 0 PC, 1 ALUOut
//  instr_we_o       out  1  IRWrite
//  reg_dst_rtrd_o   out  1  RegDst: 0 rt, 1 rd
//  mem_to_reg_o     out  1  MemtoReg: 0 ALUOut, 1 Data
//  enable_wrf_o     out  1  RegWrite
//  a_alu_input_o    out  1  ALUSrcA: 0 PC, 1 A
//  b_alu_input_o2   out  2  ALUSrcB: 00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//  alu_ctrl_o3      out  3  ALU control: 010 add, 110 sub, 000 and, 001 or, 111 slt
//  illegal_o        out  1  high while in TRAP
//  state_o4         out  4  current state encoding (debug)
// BEHAVIOUR
//  - States (4b): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6
//    ALUWB=7 BEQ=8 ADDIEX=9 ADDIWB=10 JUMP=11 BNE=12 TRAP=13; 14/15 -> FETCH.
//  - reset_i low: state=FETCH immediately; all enables (mem_req, wmem, pc_we,
//    instr_we, wrf) forced 0, illegal_o=0; selects take FETCH values.
//  - Outputs are Moore in state, except pc_we_o/instr_we_o gated by handshake/zero.
//  - FETCH: mem_req=1, IorD=0, SrcA=0, SrcB=01, alu=add, PCSrc=00; instr_we=pc_we
//    =mem_ready; stay until mem_ready, then DECODE. Exactly one PC+4 per fetch.
//  - DECODE: SrcA=0, SrcB=11, alu=add. Next: LW/SW(100011/101011)->MEMADR,
//    R(000000)->EXEC, BEQ(000100)->BEQ, ADDI(001000)->ADDIEX, J(000010)->JUMP,
//    BNE(000101)->BNE; else TRAP. EXT_OPS_EN=0: ADDI/J/BNE -> TRAP.
//  - MEMADR: SrcA=1, SrcB=10, add; ->MEMRD (LW) or MEMWR (SW).
//  - MEMRD: mem_req=1, IorD=1; wait mem_ready; ->MEMWB.
//  - MEMWB: RegDst=0, MemtoReg=1, wrf=1; ->FETCH.
//  - MEMWR: mem_req=1, IorD=1, wmem=1 every cycle held; wait mem_ready; ->FETCH.
//  - EXEC: SrcA=1, SrcB=00, alu from funct (100000 add, 100010 sub, 100100 and,
//    100101 or, 101010 slt); unknown funct -> TRAP (checked in DECODE); ->ALUWB.
//  - ALUWB: RegDst=1, MemtoReg=0, wrf=1; ->FETCH.
//  - BEQ/BNE: SrcA=1, SrcB=00, sub, PCSrc=01; pc_we=zero_i (BEQ) / ~zero_i (BNE).
//  - ADDIEX: SrcA=1, SrcB=10, add; ->ADDIWB: RegDst=0, MemtoReg=0, wrf=1; ->FETCH.
//  - JUMP: PCSrc=10, pc_we=1; ->FETCH.
//  - TRAP: all enables 0, illegal_o=1; sticky until reset_i low.
//  - Enables not listed for a state are 0; selects not listed are don't-care
//    but driven to 0. mem_ready_i ignored outside FETCH/MEMRD/MEMWR.
//  - Latency (zero-wait memory): LW 5, SW 4, R 4, ADDI 4, BEQ/BNE/J 3 cycles.
// TESTING
//  - Reset: reset_i=0 mid-EXEC -> state_o4=0 same cycle, all enables 0; release -> FETCH.
//  - LW, mem_ready 0 for 3 cycles in FETCH -> instr_we/pc_we 0 then 1 only on ready cycle; 8 cycles total.
//  - R add (op 0, funct 100000) -> alu_ctrl 010 in EXEC; ALUWB wrf=1, RegDst=1.
//  - BEQ zero_i=1 -> pc_we=1, PCSrc=01; BNE zero_i=1 -> pc_we=0; both back to FETCH.
//  - J (000010) -> JUMP, pc_we=1, PCSrc=10; EXT_OPS_EN=0 build -> TRAP, illegal_o=1.
//  - Opcode 111111 or funct 000111 -> TRAP, all enables 0 until reset.

Source files
------------

// File: rtl/mc_controller_hs.sv
// Multicycle MIPS control unit with memory ready/request handshake.
// Moore decode of the datapath FSM; PC/IR write enables gated by handshake or zero flag.
//
// state  | meaning
// FETCH  | read instruction, PC+4, wait for memory ready
// DECODE | register read, branch target precompute, opcode dispatch
// MEMADR | effective address for LW/SW
// MEMRD  | data read, wait for memory ready
// MEMWB  | load result to rt
// MEMWR  | data write held until memory ready
// EXEC   | R-type ALU operation
// ALUWB  | R-type result to rd
// BEQ    | compare, branch when equal
// ADDIEX | immediate add
// ADDIWB | immediate result to rt
// JUMP   | load jump target into PC
// BNE    | compare, branch when not equal
// TRAP   | illegal instruction, held until reset
module mc_controller_hs #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit EXT_OPS_EN  = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [5:0] op_i6,
    input  logic [5:0] funct_i6,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       enable_wmem_o,
    output logic       pc_we_o,
    output logic [1:0] pc_branch_o2,
    output logic       instr_or_data_o,
    output logic       instr_we_o,
    output logic       reg_dst_rtrd_o,
    output logic       mem_to_reg_o,
    output logic       enable_wrf_o,
    output logic       a_alu_input_o,
    output logic [1:0] b_alu_input_o2,
    output logic [2:0] alu_ctrl_o3,
    output logic       illegal_o,
    output logic [3:0] state_o4
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
        S_BNE    = 4'd12, S_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state, state_nx;
    logic   ready;
    logic   funct_ok;
    logic [2:0] funct_alu;
    logic   mem_req, wmem, pc_we, instr_we, wrf, illegal;

    assign ready = MEM_WAIT_EN ? mem_ready_i : 1'b1;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct_i6)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state <= S_FETCH;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        mem_req         = 1'b0;
        wmem            = 1'b0;
        pc_we           = 1'b0;
        instr_we        = 1'b0;
        wrf             = 1'b0;
        illegal         = 1'b0;
        pc_branch_o2    = 2'b00;
        instr_or_data_o = 1'b0;
        reg_dst_rtrd_o  = 1'b0;
        mem_to_reg_o    = 1'b0;
        a_alu_input_o   = 1'b0;
        b_alu_input_o2  = 2'b00;
        alu_ctrl_o3     = ALU_ADD;
        case (state)
            S_FETCH: begin
                mem_req        = 1'b1;
                b_alu_input_o2 = 2'b01;
                instr_we       = ready;
                pc_we          = ready;
                if (ready) state_nx = S_DECODE;
            end
            S_DECODE: begin
                b_alu_input_o2 = 2'b11;
                if (op_i6 == OP_LW || op_i6 == OP_SW)       state_nx = S_MEMADR;
                else if (op_i6 == OP_R)                     state_nx = funct_ok ? S_EXEC : S_TRAP;
                else if (op_i6 == OP_BEQ)                   state_nx = S_BEQ;
                else if (EXT_OPS_EN && op_i6 == OP_ADDI)    state_nx = S_ADDIEX;
                else if (EXT_OPS_EN && op_i6 == OP_J)       state_nx = S_JUMP;
                else if (EXT_OPS_EN && op_i6 == OP_BNE)     state_nx = S_BNE;
                else                                        state_nx = S_TRAP;
            end
            S_MEMADR: begin
                a_alu_input_o  = 1'b1;
                b_alu_input_o2 = 2'b10;
                state_nx       = (op_i6 == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req         = 1'b1;
                instr_or_data_o = 1'b1;
                if (ready) state_nx = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg_o = 1'b1;
                wrf          = 1'b1;
                state_nx     = S_FETCH;
            end
            S_MEMWR: begin
                mem_req         = 1'b1;
                instr_or_data_o = 1'b1;
                wmem            = 1'b1;
                if (ready) state_nx = S_FETCH;
            end
            S_EXEC: begin
                a_alu_input_o = 1'b1;
                alu_ctrl_o3   = funct_alu;
                state_nx      = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst_rtrd_o = 1'b1;
                wrf            = 1'b1;
                state_nx       = S_FETCH;
            end
            S_BEQ, S_BNE: begin
                a_alu_input_o = 1'b1;
                alu_ctrl_o3   = ALU_SUB;
                pc_branch_o2  = 2'b01;
                pc_we         = (state == S_BEQ) ? zero_i : ~zero_i;
                state_nx      = S_FETCH;
            end
            S_ADDIEX: begin
                a_alu_input_o  = 1'b1;
                b_alu_input_o2 = 2'b10;
                state_nx       = S_ADDIWB;
            end
            S_ADDIWB: begin
                wrf      = 1'b1;
                state_nx = S_FETCH;
            end
            S_JUMP: begin
                pc_branch_o2 = 2'b10;
                pc_we        = 1'b1;
                state_nx     = S_FETCH;
            end
            S_TRAP: begin
                illegal  = 1'b1;
                state_nx = S_TRAP;
            end
            default: state_nx = S_FETCH;
        endcase
    end

    // Reset acts on enables combinationally so FETCH's request is suppressed while held.
    assign mem_req_o     = mem_req  & reset_i;
    assign enable_wmem_o = wmem     & reset_i;
    assign pc_we_o       = pc_we    & reset_i;
    assign instr_we_o    = instr_we & reset_i;
    assign enable_wrf_o  = wrf      & reset_i;
    assign illegal_o     = illegal  & reset_i;
    assign state_o4      = state;
endmodule
